// File: rtl/usr_access_arbiter_if.sv
// Requester-side handshake and forwarded-pair bus for usr_access_arbiter.
interface usr_access_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ID_W    = 3
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ID_W-1:0]   req_id;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      out_valid;
    logic [ID_W-1:0]           out_usr_id;
    logic [DATA_W-1:0]         out_data;
    logic [NUM_REQ-1:0]        locked;

    // Requesters and the grant-stage observer.
    modport master (
        output req_valid, req_id, req_data,
        input  req_ready, out_valid, out_usr_id, out_data, locked
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_id, req_data,
        output req_ready, out_valid, out_usr_id, out_data, locked
    );
endinterface

// File: rtl/usr_access_arbiter.sv
// Round-robin arbiter feeding the user-grant-access stage, with a per-requester
// brute-force lockout after MAX_FAIL consecutive non-authorized IDs.
module usr_access_arbiter #(
    parameter int unsigned     NUM_REQ     = 4,
    parameter int unsigned     DATA_W      = 8,
    parameter int unsigned     ID_W        = 3,
    parameter logic [ID_W-1:0] GRANT_ID    = 3'b100,
    parameter int unsigned     MAX_FAIL    = 3,
    parameter int unsigned     LOCK_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    usr_access_arbiter_if.slave bus
);
    localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int unsigned TMR_W  = $clog2(LOCK_CYCLES + 1);
    localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        ST_OPEN,
        ST_LOCKED
    } lock_state_e;

    lock_state_e        state_q [NUM_REQ];
    lock_state_e        state_d [NUM_REQ];
    logic [FAIL_W-1:0]  fail_q  [NUM_REQ];
    logic [FAIL_W-1:0]  fail_d  [NUM_REQ];
    logic [TMR_W-1:0]   timer_q [NUM_REQ];
    logic [TMR_W-1:0]   timer_d [NUM_REQ];

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               out_valid_q;
    logic [ID_W-1:0]    out_usr_id_q;
    logic [DATA_W-1:0]  out_data_q;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   idx;
    logic               xfer;
    logic [ID_W-1:0]    sel_id;
    logic [DATA_W-1:0]  sel_data;

    // Round-robin search from rr_ptr_q; first eligible index wins (one-hot).
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (grant == '0 && eligible[idx]) begin
                grant[idx] = 1'b1;
            end
        end
    end

    // Mux the winner's pair; zeros when nothing transfers so no stale data lingers.
    always_comb begin
        xfer     = 1'b0;
        sel_id   = '0;
        sel_data = '0;
        rr_ptr_d = rr_ptr_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                xfer     = 1'b1;
                sel_id   = bus.req_id[i*ID_W +: ID_W];
                sel_data = bus.req_data[i*DATA_W +: DATA_W];
                rr_ptr_d = PTR_W'((i + 1) % NUM_REQ);
            end
        end
    end

    // Forwarded-pair register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_usr_id_q <= '0;
            out_data_q   <= '0;
            rr_ptr_q     <= '0;
        end else begin
            out_valid_q  <= xfer;
            out_usr_id_q <= sel_id;
            out_data_q   <= sel_data;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    // Lockout FSM state register, one instance per requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                state_q[i] <= ST_OPEN;
                fail_q[i]  <= '0;
                timer_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                state_q[i] <= state_d[i];
                fail_q[i]  <= fail_d[i];
                timer_q[i] <= timer_d[i];
            end
        end
    end

    // Lockout FSM next state: count failed transfers, lock at MAX_FAIL, count down to release.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            state_d[i] = state_q[i];
            fail_d[i]  = fail_q[i];
            timer_d[i] = timer_q[i];
            case (state_q[i])
                ST_OPEN: begin
                    if (grant[i]) begin
                        if (bus.req_id[i*ID_W +: ID_W] == GRANT_ID) begin
                            fail_d[i] = '0;
                        end else if (fail_q[i] >= FAIL_W'(MAX_FAIL - 1)) begin
                            fail_d[i]  = FAIL_W'(MAX_FAIL);
                            state_d[i] = ST_LOCKED;
                            timer_d[i] = TMR_W'(LOCK_CYCLES);
                        end else begin
                            fail_d[i] = fail_q[i] + 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    // Timer holds the number of locked cycles still to come,
                    // including the current one, so release happens as it hits 0.
                    if (timer_q[i] <= TMR_W'(1)) begin
                        state_d[i] = ST_OPEN;
                        timer_d[i] = '0;
                        fail_d[i]  = '0;
                    end else begin
                        timer_d[i] = timer_q[i] - 1'b1;
                    end
                end
                default: begin
                    state_d[i] = ST_OPEN;
                end
            endcase
        end
    end

    // Lockout FSM outputs: locked flags straight from state, eligibility gated by reset.
    always_comb begin
        eligible   = '0;
        bus.locked = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            bus.locked[i] = (state_q[i] == ST_LOCKED);
            eligible[i]   = !rst && bus.req_valid[i] && (state_q[i] == ST_OPEN);
        end
    end

    assign bus.req_ready  = grant;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_usr_id = out_usr_id_q;
    assign bus.out_data   = out_data_q;

endmodule

// File: tb/tb_usr_access_arbiter.sv
// Self-checking bench for usr_access_arbiter: directed table, hand-written
// lockout/reset sequences and random traffic against a remaining-cycles model.
module tb_usr_access_arbiter;
    localparam int NUM_REQ     = 4;
    localparam int DATA_W      = 8;
    localparam int ID_W        = 3;
    localparam int MAX_FAIL    = 3;
    localparam int LOCK_CYCLES = 16;
    localparam logic [2:0] GID = 3'b100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    usr_access_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

    usr_access_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W),
        .GRANT_ID(GID), .MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: consecutive-fail count, locked cycles still to come, rr pointer.
    int m_fail [NUM_REQ];
    int m_lock [NUM_REQ];
    int m_rr;
    logic [3:0] last_rdy;

    typedef struct {
        logic [3:0]  v;
        logic [11:0] ids;
        logic [31:0] dat;
        logic [3:0]  rdy;
        logic        ov;
        logic [2:0]  oid;
        logic [7:0]  od;
    } vec_t;
    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            m_fail[i] = 0;
            m_lock[i] = 0;
        end
        m_rr = 0;
    endtask

    // One cycle: drive at posedge+1, check ready at +3, check registered outputs at next posedge+1.
    task automatic step(input logic [3:0] v, input logic [11:0] ids, input logic [31:0] dat);
        int w;
        logic [3:0] er;
        logic ev;
        logic [2:0] eid;
        logic [7:0] ed;
        logic [3:0] el;
        w = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w < 0 && v[(m_rr + k) % NUM_REQ] && m_lock[(m_rr + k) % NUM_REQ] == 0)
                w = (m_rr + k) % NUM_REQ;
        end
        er = '0;
        if (w >= 0) er[w] = 1'b1;
        bus.req_valid = v;
        bus.req_id    = ids;
        bus.req_data  = dat;
        #2;
        last_rdy = bus.req_ready;
        check("ready", bus.req_ready, er);
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (m_lock[i] > 0) begin
                m_lock[i]--;
                if (m_lock[i] == 0) m_fail[i] = 0;
            end
        end
        if (w >= 0) begin
            eid = ids[w*ID_W +: ID_W];
            ed  = dat[w*DATA_W +: DATA_W];
            ev  = 1'b1;
            if (eid == GID) m_fail[w] = 0;
            else begin
                m_fail[w]++;
                if (m_fail[w] >= MAX_FAIL) m_lock[w] = LOCK_CYCLES;
            end
            m_rr = (w + 1) % NUM_REQ;
        end else begin
            ev  = 1'b0;
            eid = '0;
            ed  = '0;
        end
        for (int i = 0; i < NUM_REQ; i++) el[i] = (m_lock[i] > 0);
        check("out_valid", bus.out_valid, ev);
        check("out_usr_id", bus.out_usr_id, eid);
        check("out_data", bus.out_data, ed);
        check("locked", bus.locked, el);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  rv;
        logic [11:0] rid;
        logic [31:0] rdat;
        int n;

        tbl[0] = '{4'hf, 12'h924, 32'h13121110, 4'h1, 1'b1, 3'b100, 8'h10};
        tbl[1] = '{4'hf, 12'h924, 32'h13121110, 4'h2, 1'b1, 3'b100, 8'h11};
        tbl[2] = '{4'hf, 12'h924, 32'h13121110, 4'h4, 1'b1, 3'b100, 8'h12};
        tbl[3] = '{4'hf, 12'h924, 32'h13121110, 4'h8, 1'b1, 3'b100, 8'h13};
        tbl[4] = '{4'hf, 12'h924, 32'h13121110, 4'h1, 1'b1, 3'b100, 8'h10};
        tbl[5] = '{4'h1, 12'h004, 32'h000000a1, 4'h1, 1'b1, 3'b100, 8'ha1};
        tbl[6] = '{4'h0, 12'h000, 32'h00000000, 4'h0, 1'b0, 3'b000, 8'h00};

        // Reset with every requester valid.
        rst = 1'b1;
        bus.req_valid = '1;
        bus.req_id    = 12'h924;
        bus.req_data  = 32'hdeadbeef;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check("rst_ready", bus.req_ready, 4'h0);
            check("rst_out_valid", bus.out_valid, 1'b0);
            check("rst_out_usr_id", bus.out_usr_id, 3'b000);
            check("rst_locked", bus.locked, 4'h0);
        end
        rst = 1'b0;
        model_reset();

        // Round-robin and idle scrub from the table.
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].v, tbl[i].ids, tbl[i].dat);
            check("tbl_ready", last_rdy, tbl[i].rdy);
            check("tbl_out_valid", bus.out_valid, tbl[i].ov);
            check("tbl_out_usr_id", bus.out_usr_id, tbl[i].oid);
            check("tbl_out_data", bus.out_data, tbl[i].od);
        end

        // Lockout of requester 1 with three non-authorized transfers.
        step(4'h2, 12'h028, 32'h00000100);
        check("lk_data0", bus.out_data, 8'h01);
        step(4'h2, 12'h028, 32'h00000800);
        check("lk_data1", bus.out_data, 8'h08);
        check("lk_not_yet", bus.locked[1], 1'b0);
        step(4'h2, 12'h028, 32'h0000f100);
        check("lk_data2", bus.out_data, 8'hf1);
        check("lk_set", bus.locked[1], 1'b1);
        n = 0;
        while (bus.locked[1] === 1'b1 && n < 40) begin
            step(4'h2, 12'h020, 32'h00003300);
            check("lk_ready_low", last_rdy[1], 1'b0);
            n++;
        end
        check("lk_len", n, LOCK_CYCLES);
        step(4'h2, 12'h020, 32'h00003300);
        check("lk_release_id", bus.out_usr_id, 3'b100);
        step(4'h2, 12'h028, 32'h00000100);
        step(4'h2, 12'h028, 32'h00000100);
        check("lk_count_restart", bus.locked[1], 1'b0);

        // Fail count clears on an authorized ID.
        step(4'h4, 12'h080, 32'h00010000);
        step(4'h4, 12'h0c0, 32'h00020000);
        step(4'h4, 12'h100, 32'h00030000);
        step(4'h4, 12'h080, 32'h00040000);
        step(4'h4, 12'h0c0, 32'h00050000);
        check("fr_no_lock", bus.locked[2], 1'b0);

        // Reset during a lockout of requester 3.
        for (int i = 0; i < 3; i++) step(4'h8, 12'h000, 32'h77000000);
        check("rl_set", bus.locked[3], 1'b1);
        for (int i = 0; i < 4; i++) step(4'h0, 12'h000, 32'h00000000);
        rst = 1'b1;
        bus.req_valid = '0;
        @(posedge clk);
        #1;
        check("rl_cleared", bus.locked, 4'h0);
        check("rl_out_valid", bus.out_valid, 1'b0);
        rst = 1'b0;
        model_reset();
        step(4'h8, 12'h800, 32'h5a000000);
        check("rl_accept", bus.out_data, 8'h5a);
        step(4'h8, 12'h000, 32'h01000000);
        step(4'h8, 12'h000, 32'h02000000);
        check("rl_fail_zero", bus.locked[3], 1'b0);
        step(4'h8, 12'h000, 32'h03000000);
        check("rl_relock", bus.locked[3], 1'b1);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            rv = 4'($urandom);
            for (int i = 0; i < NUM_REQ; i++) begin
                rid[i*ID_W +: ID_W] = ($urandom_range(0, 1) == 1) ? GID : 3'($urandom_range(0, 7));
            end
            rdat = $urandom;
            step(rv, rid, rdat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
